// File: rtl/bp_pkg.sv
// Shared constants and helpers for the branch history cache.
package bp_pkg;

    // The per-set LRU bit holds the index of the way to evict next.
    localparam logic LRU_RST = 1'b0;

    // Weakly not-taken counter value: 2^(ctr_bits-1) - 1.
    function automatic int ctr_wnt(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

    // Weakly taken counter value: 2^(ctr_bits-1).
    function automatic int ctr_wt(input int ctr_bits);
        return 1 << (ctr_bits - 1);
    endfunction

    // Set index: pc[idx_bits+1:2]; the byte offset pc[1:0] is ignored.
    function automatic logic [31:0] pc_index(input logic [63:0] pc, input int idx_bits);
        logic [63:0] mask;
        mask = (64'd1 << idx_bits) - 64'd1;
        return 32'((pc >> 2) & mask);
    endfunction

    // Tag: everything above the index bits.
    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_bits);
        return pc >> (idx_bits + 2);
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter next-value logic used for hit updates.
module bp_sat_counter #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                taken,
    output logic [CTR_BITS-1:0] ctr_nxt
);

    // Step toward the observed direction, holding at both ends.
    always_comb begin
        ctr_nxt = ctr;
        if (taken) begin
            if (!(&ctr)) ctr_nxt = ctr + CTR_BITS'(1);
        end else begin
            if (ctr != '0) ctr_nxt = ctr - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/bp_cache.sv
// Set-associative branch direction predictor with saturating counters and LRU.
module bp_cache
    import bp_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int LINES     = 8,
    parameter int WAYS      = 2,
    parameter int CTR_BITS  = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [PC_WIDTH-1:0]  guess_pc,
    input  logic                 guess_valid,
    output logic                 guess_hit,
    output logic                 guess_taken,
    input  logic [PC_WIDTH-1:0]  check_pc,
    input  logic                 check_valid,
    input  logic                 check_taken,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
);

    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = PC_WIDTH - IDX - 2;

    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(ctr_wnt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(ctr_wt(CTR_BITS));

    // Flop-based storage so both lookups read asynchronously.
    logic                valid_q [LINES][WAYS];
    logic [TAG_W-1:0]    tag_q   [LINES][WAYS];
    logic [CTR_BITS-1:0] ctr_q   [LINES][WAYS];
    logic                lru_q   [LINES];

    logic [IDX-1:0]      gidx, cidx;
    logic [TAG_W-1:0]    gtag, ctag;
    logic                g_match, g_msb;
    logic                c_hit;
    int                  c_way, victim, upd_way;
    logic [CTR_BITS-1:0] c_ctr, ctr_nxt;

    assign gidx = IDX'(pc_index(64'(guess_pc), IDX));
    assign gtag = TAG_W'(pc_tag(64'(guess_pc), IDX));
    assign cidx = IDX'(pc_index(64'(check_pc), IDX));
    assign ctag = TAG_W'(pc_tag(64'(check_pc), IDX));

    // Guess lookup: pure read of the current state, never updates LRU.
    always_comb begin
        g_match = 1'b0;
        g_msb   = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[gidx][w] && (tag_q[gidx][w] == gtag)) begin
                g_match = 1'b1;
                g_msb   = ctr_q[gidx][w][CTR_BITS-1];
            end
        end
    end

    assign guess_hit   = en & guess_valid & g_match;
    assign guess_taken = guess_hit & g_msb;

    // Check lookup and victim choice: first invalid way, else the LRU way.
    always_comb begin
        c_hit  = 1'b0;
        c_way  = 0;
        c_ctr  = '0;
        victim = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[cidx][w] && (tag_q[cidx][w] == ctag)) begin
                c_hit = 1'b1;
                c_way = w;
                c_ctr = ctr_q[cidx][w];
            end
        end
        if (WAYS == 2) victim = int'(lru_q[cidx]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[cidx][w]) victim = w;
        end
        upd_way = c_hit ? c_way : victim;
    end

    bp_sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) u_sat (
        .ctr     (c_ctr),
        .taken   (check_taken),
        .ctr_nxt (ctr_nxt)
    );

    // Table and performance counter update on resolved branches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < LINES; s++) begin
                lru_q[s] <= LRU_RST;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    ctr_q[s][w]   <= CTR_WNT;
                end
            end
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (en && check_valid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (w == upd_way) begin
                    if (c_hit) begin
                        ctr_q[cidx][w] <= ctr_nxt;
                    end else begin
                        valid_q[cidx][w] <= 1'b1;
                        tag_q[cidx][w]   <= ctag;
                        ctr_q[cidx][w]   <= check_taken ? CTR_WT : CTR_WNT;
                    end
                end
            end
            // The way just used becomes MRU, so the other way is next to go.
            lru_q[cidx] <= (WAYS == 2) && (upd_way == 0);
            if (c_hit) hit_cnt  <= hit_cnt + CNT_WIDTH'(1);
            else       miss_cnt <= miss_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_bp_cache.sv
// Directed, table-driven bench for bp_cache with default parameters.
module tb_bp_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] guess_pc;
    logic        guess_valid;
    logic        guess_hit;
    logic        guess_taken;
    logic [31:0] check_pc;
    logic        check_valid;
    logic        check_taken;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int errors = 0;
    int checks = 0;

    bp_cache dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .guess_pc    (guess_pc),
        .guess_valid (guess_valid),
        .guess_hit   (guess_hit),
        .guess_taken (guess_taken),
        .check_pc    (check_pc),
        .check_valid (check_valid),
        .check_taken (check_taken),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        gv;
        logic [31:0] gpc;
        logic        cv;
        logic [31:0] cpc;
        logic        ct;
        logic        eh;
        logic        et;
        int          ehc;
        int          emc;
    } vec_t;

    vec_t vecs[$];

    // Expected values describe the state before this cycle's update lands.
    task automatic add(input logic e, input logic gv, input logic [31:0] gpc,
                       input logic cv, input logic [31:0] cpc, input logic ct,
                       input logic eh, input logic et, input int ehc, input int emc);
        vec_t v;
        v.en = e; v.gv = gv; v.gpc = gpc; v.cv = cv; v.cpc = cpc; v.ct = ct;
        v.eh = eh; v.et = et; v.ehc = ehc; v.emc = emc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; guess_valid = 1'b0; guess_pc = '0;
        check_valid = 1'b0; check_pc = '0; check_taken = 1'b0;

        // Reset then lookup; fill and train with saturation at 0
        add(1,1,32'h40000010, 0,32'h0,        0, 0,0, 0,0);
        add(1,1,32'h40000010, 1,32'h40000010, 1, 0,0, 0,0);
        add(1,1,32'h40000010, 1,32'h40000010, 0, 1,1, 0,1);
        add(1,1,32'h40000010, 1,32'h40000010, 0, 1,0, 1,1);
        add(1,1,32'h40000010, 1,32'h40000010, 0, 1,0, 2,1);
        add(1,1,32'h40000010, 0,32'h0,        0, 1,0, 3,1);
        // Conflict in set 0 and LRU eviction
        add(1,1,32'h00, 1,32'h00, 1, 0,0, 3,1);
        add(1,1,32'h00, 1,32'h20, 1, 1,1, 3,2);
        add(1,1,32'h20, 1,32'h40, 0, 1,1, 3,3);
        add(1,1,32'h20, 0,32'h0,  0, 1,1, 3,4);
        add(1,1,32'h40, 0,32'h0,  0, 1,0, 3,4);
        add(1,1,32'h00, 0,32'h0,  0, 0,0, 3,4);
        add(1,1,32'h20, 1,32'h20, 1, 1,1, 3,4);
        add(1,1,32'h60, 1,32'h60, 1, 0,0, 4,4);
        add(1,1,32'h40, 0,32'h0,  0, 0,0, 4,5);
        add(1,1,32'h60, 0,32'h0,  0, 1,1, 4,5);
        add(1,1,32'h20, 0,32'h0,  0, 1,1, 4,5);
        // Same-cycle guess and check: no bypass (evicts 0x20 from set 0)
        add(1,1,32'h100, 1,32'h100, 1, 0,0, 4,5);
        add(1,1,32'h100, 0,32'h0,   0, 1,1, 4,6);
        add(1,1,32'h20,  0,32'h0,   0, 0,0, 4,6);
        // Enable gating (0x80 also maps to set 0 and evicts 0x60)
        add(1,1,32'h80, 1,32'h80, 1, 0,0, 4,6);
        add(1,1,32'h80, 1,32'h80, 1, 1,1, 4,7);
        add(0,1,32'h80, 1,32'h80, 0, 0,0, 5,7);
        add(0,1,32'h80, 1,32'h80, 0, 0,0, 5,7);
        add(0,1,32'h80, 1,32'h80, 0, 0,0, 5,7);
        add(0,1,32'h80, 1,32'h80, 0, 0,0, 5,7);
        add(1,1,32'h80, 0,32'h0,  0, 1,1, 5,7);
        add(1,0,32'h80, 0,32'h0,  0, 0,0, 5,7);
        // Saturation at the top, then a single step down
        add(1,1,32'h80, 1,32'h80, 1, 1,1, 5,7);
        add(1,1,32'h80, 1,32'h80, 0, 1,1, 6,7);
        add(1,1,32'h80, 0,32'h0,  0, 1,1, 7,7);
        add(1,1,32'h83, 0,32'h0,  0, 1,1, 7,7);

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            en = vecs[i].en; guess_valid = vecs[i].gv; guess_pc = vecs[i].gpc;
            check_valid = vecs[i].cv; check_pc = vecs[i].cpc; check_taken = vecs[i].ct;
            #2;
            chk($sformatf("v%0d_hit", i),   32'(guess_hit),   32'(vecs[i].eh));
            chk($sformatf("v%0d_taken", i), 32'(guess_taken), 32'(vecs[i].et));
            chk($sformatf("v%0d_hitcnt", i),  hit_cnt,  32'(vecs[i].ehc));
            chk($sformatf("v%0d_misscnt", i), miss_cnt, 32'(vecs[i].emc));
        end

        // Asynchronous reset between edges while a check is pending
        @(posedge clk);
        #1;
        en = 1'b1; guess_valid = 1'b1; guess_pc = 32'h80;
        check_valid = 1'b1; check_pc = 32'h80; check_taken = 1'b1;
        #2 chk("pre_rst_hit", 32'(guess_hit), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rst_hit",     32'(guess_hit),   32'd0);
        chk("rst_taken",   32'(guess_taken), 32'd0);
        chk("rst_hitcnt",  hit_cnt,  32'd0);
        chk("rst_misscnt", miss_cnt, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_misscnt", miss_cnt, 32'd0);
        check_valid = 1'b0;
        #1 rst = 1'b1;
        #1 chk("post_rst_hit", 32'(guess_hit), 32'd0);
        check_valid = 1'b1;
        @(posedge clk);
        #1;
        check_valid = 1'b0;
        chk("post_rst_misscnt", miss_cnt, 32'd1);
        chk("post_rst_hitcnt",  hit_cnt,  32'd0);
        #1 chk("post_rst_refill", 32'(guess_hit), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_cache.md
Name: bp_cache

Overview:
- Parametrised branch history cache serving the pipelined core's fetch/decode stage.
- Predicts taken/not-taken for a branch PC.
- Learns from resolved branches in execute.
- Set-associative with per-entry saturating counters and per-set LRU replacement.
- Gated by the core's bp_enable; when disabled it behaves as a static not-taken predictor.

Parameters:
- PC_WIDTH, 32, branch PC width.
- LINES, 8, number of sets; power of two, at least 2.
- WAYS, 2, associativity; legal values are 1 or 2.
- CTR_BITS, 2, saturating counter width, at least 1.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  predictor enable (driven from bp_enable).
- guess_pc  in  PC_WIDTH  PC of the branch in decode.
- guess_valid  in  1  guess request is valid.
- guess_hit  out  1  guess_pc matched a valid entry.
- guess_taken  out  1  predicted direction.
- check_pc  in  PC_WIDTH  PC of the branch resolved in execute.
- check_valid  in  1  resolution is valid this cycle.
- check_taken  in  1  actual branch outcome.
- hit_cnt  out  CNT_WIDTH  number of check lookups that hit.
- miss_cnt  out  CNT_WIDTH  number of check lookups that missed.

Behaviour:
- Address split
  - IDX = log2(LINES).
  - index = pc[IDX+1:2].
  - tag = pc[PC_WIDTH-1:IDX+2].
  - pc[1:0] is ignored.
- Reset (rst low, asynchronous)
  - All valid bits cleared.
  - All counters set to weakly not-taken (2^(CTR_BITS-1) - 1).
  - LRU bits set to 0.
  - hit_cnt and miss_cnt set to 0.
  - Consequently guess_hit and guess_taken are 0.
  - Reset asserted mid-update wins; no partial update survives.
- Guess path is combinational, zero-cycle latency (same cycle as guess_pc).
  - guess_hit = en & guess_valid & (some way has valid set and a matching tag).
  - guess_taken = guess_hit & MSB of the hitting way's counter.
  - On a miss, or when en = 0: both outputs are 0.
  - The guess path never modifies state, including LRU.
- Check/update path is synchronous; it acts only when en & check_valid.
  - Hit in way w:
    - Counter increments if check_taken, decrements otherwise.
    - Counter saturates at 2^CTR_BITS - 1 and at 0; no wrap.
    - LRU of the set := the other way (if WAYS = 2).
    - hit_cnt increments.
  - Miss, victim selection:
    - The first invalid way, lowest index first.
    - Otherwise the LRU way.
    - WAYS = 1: always way 0.
  - Miss, fill:
    - Write the tag and set valid.
    - Counter := weakly taken (2^(CTR_BITS-1)) if check_taken, else weakly not-taken.
    - LRU := the other way.
    - miss_cnt increments.
  - hit_cnt and miss_cnt wrap modulo 2^CNT_WIDTH.
- Simultaneous guess and check to the same set or PC: the guess reads the pre-update state; there is no bypass. The update is visible to guesses from the next cycle.
- en deasserted: no updates and no counter increments. Stored state is retained; it is not cleared.
- A tag match in both ways cannot occur by construction; it is not checked.

Decomposition:
- Package bp_pkg holds:
  - the counter constants CTR_WNT and CTR_WT, as functions of CTR_BITS;
  - the index/tag slicing function;
  - an LRU encoding constant.
- Sub-module bp_sat_counter (CTR_BITS): combinational next-value function taking counter and taken, producing the saturated counter. It is instanced for the hit update only; the fill value comes from the package constants.
- Per-set, per-way arrays of valid, tag and counter, plus a per-set LRU bit, live in bp_cache as flops, not RAM, so reads stay asynchronous.

Test Plan:
- Reset then lookup:
  - Stimulus: rst low 2 cycles, release; guess_pc = 0x40000010, guess_valid = 1.
  - Required: guess_hit = 0, guess_taken = 0, hit_cnt = 0, miss_cnt = 0.
- Fill and train:
  - Stimulus: check_pc = 0x40000010, check_taken = 1, check_valid = 1 for one cycle.
  - Required next cycle: guess on the same PC gives hit = 1, taken = 1, miss_cnt = 1.
  - Then 3 not-taken checks: counter goes 2 → 1 → 0 → 0 (saturates); guess_taken = 0; hit_cnt = 3.
- Conflict and LRU (defaults LINES = 8, WAYS = 2):
  - Stimulus: fill PC 0x00, 0x20, 0x40 in turn; all share index 0.
  - Required: 0x00 is evicted; guesses give 0x20 hit, 0x40 hit, 0x00 miss.
  - Then touch 0x20 and fill 0x60: 0x40 is evicted.
- Same-cycle bypass rule:
  - Stimulus: guess and check on PC 0x100 (empty) in the same cycle, check_taken = 1.
  - Required: guess_hit = 0 that cycle and hit = 1 the following cycle.
- Enable gating:
  - Stimulus: train 0x80 to taken, deassert en, issue 4 not-taken checks, then reassert en.
  - Required: while en = 0, guess outputs are 0 and counters do not move. After re-enable, guess_taken = 1 and hit_cnt is unchanged by the 4 disabled checks.
- Async reset mid-operation:
  - Stimulus: pull rst low between clock edges while check_valid = 1.
  - Required: outputs drop to 0 immediately; the following hit on the trained PC reads as a miss.
